// File: rtl/prom_port_arbiter.sv
// prom_port_arbiter: round-robin sharing of one single-cycle PROM RAM port between two requesters
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 per-requester valid/ready request (we, addr, wdata)
//   rsp_*                 per-requester held response (valid/ready, rdata, err)
//   ram_*                 shared synchronous RAM port, rdata valid the cycle after ram_en
module prom_port_arbiter #(
  parameter int ADDR_BITS  = 15,
  parameter int DATA_WIDTH = 8,
  parameter int PROM_DEPTH = 20480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [ADDR_BITS-1:0]  req0_addr,
  input  logic [ADDR_BITS-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [1:0]            rsp_err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam logic [ADDR_BITS:0] DEPTH = PROM_DEPTH[ADDR_BITS:0];
  logic [1:0] inflight, we_l, err_l, elig;
  logic last_grant, g, any_grant, in_range;
  logic [ADDR_BITS-1:0] addr_g;
  logic [DATA_WIDTH-1:0] wdata_g;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  // a requester with a held, unaccepted response cannot issue again
  assign elig = req_valid & ~inflight & (~rsp_valid | rsp_ready);
  always_comb begin
    g         = (elig == 2'b11) ? ~last_grant : elig[1];
    any_grant = rst_n && (|elig);
    req_ready = any_grant ? (g ? 2'b10 : 2'b01) : 2'b00;
    addr_g    = g ? req1_addr : req0_addr;
    wdata_g   = g ? req1_wdata : req0_wdata;
    in_range  = {1'b0, addr_g} < DEPTH;
    ram_en    = any_grant && in_range;
    ram_we    = ram_en && req_we[g];
    ram_addr  = any_grant ? addr_g : '0;
    ram_wdata = any_grant ? wdata_g : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      inflight   <= '0;
      we_l       <= '0;
      err_l      <= '0;
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      if (any_grant) last_grant <= g;
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          inflight[i] <= 1'b1;
          we_l[i]     <= req_we[i];
          err_l[i]    <= !in_range;
        end else if (inflight[i]) begin
          inflight[i] <= 1'b0;
        end
        // ram_rdata belongs to this requester only in the cycle after its grant
        if (inflight[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_err[i]   <= err_l[i];
          rdata_q[i]   <= (we_l[i] || err_l[i]) ? '0 : ram_rdata;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end
  assign rsp0_rdata = rdata_q[0];
  assign rsp1_rdata = rdata_q[1];
endmodule

// File: tb/tb_prom_port_arbiter.sv
// tb_prom_port_arbiter: directed checks of prom_port_arbiter against a behavioural RAM
module tb_prom_port_arbiter;
  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = 0, req_ready, req_we = 0, rsp_valid, rsp_ready = 0, rsp_err;
  logic [14:0] req0_addr = 0, req1_addr = 0, ram_addr;
  logic [7:0] req0_wdata = 0, req1_wdata = 0, rsp0_rdata, rsp1_rdata, ram_wdata, ram_rdata = 0;
  logic ram_en, ram_we;
  logic [7:0] mem [0:32767];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  prom_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req0_addr(req0_addr), .req1_addr(req1_addr), .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp0_rdata(rsp0_rdata), .rsp1_rdata(rsp1_rdata),
    .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input int r, input bit we, input logic [14:0] a, input logic [7:0] wd,
                      input bit en, input logic [7:0] rd, input bit er);
    step();
    req_valid = 2'b01 << r;
    req_we = we ? (2'b01 << r) : 2'b00;
    if (r == 0) begin req0_addr = a; req0_wdata = wd; end
    else begin req1_addr = a; req1_wdata = wd; end
    rsp_ready = 0;
    @(negedge clk);
    chk("grant", req_ready, 2'b01 << r);
    chk("ram_en", ram_en, en);
    chk("ram_we", ram_we, en && we);
    chk("ram_addr", ram_addr, a);
    step();
    req_valid = 0;
    req_we = 0;
    @(negedge clk);
    chk("rsp_early", rsp_valid[r], 0);
    step();
    @(negedge clk);
    chk("rsp_valid", rsp_valid[r], 1);
    chk("rdata", r ? rsp1_rdata : rsp0_rdata, rd);
    chk("err", rsp_err[r], er);
    step();
    rsp_ready = 2'b01 << r;
    @(negedge clk);
    chk("rsp_hold", rsp_valid[r], 1);
    step();
    rsp_ready = 0;
    @(negedge clk);
    chk("rsp_clr", rsp_valid[r], 0);
  endtask
  initial begin
    mem[15'h0010] = 8'hA5;
    mem[15'h0020] = 8'h5A;
    mem[15'h0FFF] = 8'h11;
    mem[15'h1000] = 8'h22;
    req_valid = 2'b11;
    req0_addr = 15'h0010;
    req1_addr = 15'h0020;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rsp", rsp_valid, 0);
    step();
    req_valid = 0;
    rst_n = 1;
    // single read
    xact(0, 0, 15'h0010, 8'h00, 1, 8'hA5, 0);
    // both requesting, immediate accept: strict alternation, port busy every cycle
    step();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_en", ram_en, 1);
      step();
    end
    req_valid = 0;
    repeat (3) step();
    rsp_ready = 0;
    // write, read back, out-of-range at the top of the PROM
    xact(1, 1, 15'h4FFF, 8'h3C, 1, 8'h00, 0);
    xact(1, 0, 15'h4FFF, 8'h00, 1, 8'h3C, 0);
    xact(1, 0, 15'h5000, 8'h00, 0, 8'h00, 1);
    // req0 response held unaccepted while req1 keeps being served
    step();
    req_valid = 2'b01;
    req0_addr = 15'h0010;
    step();
    req_valid = 0;
    step();
    req_valid = 2'b11;
    req1_addr = 15'h0020;
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_grant", req_ready, (k % 2 == 0) ? 2'b10 : 2'b00);
      chk("hold_valid", rsp_valid[0], 1);
      chk("hold_rdata", rsp0_rdata, 8'hA5);
      if (k == 2) chk("hold_rsp1", {rsp_valid[1], rsp1_rdata}, {1'b1, 8'h5A});
      step();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("hold_release", req_ready, 2'b01);
    step();
    req_valid = 0;
    repeat (3) step();
    rsp_ready = 0;
    // reset in the cycle after a grant, with another response held
    req_valid = 2'b10;
    step();
    req_valid = 0;
    step();
    @(negedge clk);
    chk("pre_rst_rsp", rsp_valid, 2'b10);
    step();
    req_valid = 2'b01;
    @(negedge clk);
    chk("pre_rst_grant", req_ready, 2'b01);
    step();
    req_valid = 0;
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_en", ram_en, 0);
    step();
    @(negedge clk);
    chk("mid_rst_rsp2", rsp_valid, 0);
    step();
    rst_n = 1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 2'b01);
    chk("post_rst_rsp", rsp_valid, 0);
    step();
    req_valid = 0;
    repeat (3) step();
    rsp_ready = 0;
    // back-to-back across a 4 KB bank boundary
    req_valid = 2'b01;
    req0_addr = 15'h0FFF;
    @(negedge clk);
    chk("bank_addr0", ram_addr, 15'h0FFF);
    step();
    req_valid = 2'b10;
    req1_addr = 15'h1000;
    @(negedge clk);
    chk("bank_addr1", ram_addr, 15'h1000);
    chk("bank_grant1", req_ready, 2'b10);
    step();
    req_valid = 0;
    @(negedge clk);
    chk("bank_rsp0", {rsp_valid, rsp0_rdata}, {2'b01, 8'h11});
    step();
    @(negedge clk);
    chk("bank_rsp1", {rsp_valid, rsp1_rdata}, {2'b11, 8'h22});
    chk("bank_rsp0_hold", rsp0_rdata, 8'h11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
